video_frame_arbiter: RTL and testbench
======================================

Name: video_frame_arbiter

Overview:
- Frame-level arbiter that shares one AXI-stream video output (tuser = SOF, tlast = EOL, no tready) between two video sources.
- Grants a source only at a start-of-frame and holds the grant until that frame's last line completes. Beats from the other source are discarded.
- Checks line length and frame height on the granted stream.
- Sits in front of the line-packing/re-timing stages in the pixel_clk domain.

Parameters:
- DATA_WIDTH, 8, pixel data width.
- IMG_WIDTH, 640, beats per line (tlast expected on beat IMG_WIDTH-1).
- IMG_HEIGHT, 480, lines per frame.

Ports:
- pixel_clk  in  1  pixel clock, all logic on rising edge
- pixel_rst_n  in  1  asynchronous active-low reset
- cfg_mode  in  2  0 = src0 only, 1 = src1 only, 2 = round-robin per frame, 3 = fixed priority src0
- s0_axis_tdata/tlast/tuser/tvalid  in  DATA_WIDTH/1/1/1  source 0
- s1_axis_tdata/tlast/tuser/tvalid  in  DATA_WIDTH/1/1/1  source 1
- m_axis_tdata/tlast/tuser/tvalid  out  DATA_WIDTH/1/1/1  arbitrated stream
- active_src  out  1  source currently or last granted
- busy  out  1  high in STREAM
- err_line  out  1  one-cycle pulse: tlast with wrong pixel count
- err_frame  out  1  one-cycle pulse: SOF on granted source before IMG_HEIGHT lines
- drop_cnt  out  16  dropped-frame counter (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state IDLE, all m_axis_* = 0, active_src = 0, busy = 0, err_* = 0, drop_cnt = 0, pix_cnt = 0, line_cnt = 0, last_src = 1 (so round-robin serves src0 first).
- SOFn = sn_axis_tvalid & sn_axis_tuser.
- Eligibility:
  - Mode 0: only src0 eligible.
  - Mode 1: only src1 eligible.
  - Modes 2 and 3: both eligible.
  - cfg_mode is sampled only in IDLE; a change during STREAM takes effect at the next IDLE decision.
- IDLE:
  - On an eligible SOF, grant that source and go to STREAM.
  - The SOF beat is forwarded in the same decision cycle; no beat is lost.
  - Both SOFs in the same cycle: mode 2 grants !last_src; mode 3 grants src0.
  - Non-SOF beats in IDLE are discarded.
- STREAM: forward the granted source; the other source is ignored.
  - pix_cnt (12 bit) increments on each granted valid beat.
  - On granted tlast: if pix_cnt != IMG_WIDTH-1, pulse err_line. Then pix_cnt clears and line_cnt (12 bit) increments.
  - tlast with line_cnt == IMG_HEIGHT-1 ends the frame: last_src <= granted source; next state IDLE.
  - A new SOF can be granted in the cycle immediately after the frame-ending beat.
  - SOF on the granted source mid-frame (pix_cnt or line_cnt != 0): pulse err_frame, clear both counters, stay in STREAM, forward the beat. This is a frame restart.
- Gaps where tvalid = 0 do not advance counters.
- Output pipeline: one register stage.
  - m_axis_* reflect the selected input beat 1 cycle later.
  - m_axis_tvalid = 0 for discarded or idle cycles; m_axis_tdata, tlast and tuser are driven 0 whenever tvalid = 0.
  - err_* pulses are aligned with the output beat that caused them.
- active_src and busy update in the cycle the output beat appears.
- Reset asserted mid-frame: the frame is abandoned immediately; after release the arbiter waits for a fresh SOF.

Optional Feature:
- Macro: VIDEO_FRAME_ARBITER_DROP_CNT_EN.
- When defined: drop_cnt increments by 1 per SOF on a source that is not granted in that cycle. This covers an SOF on the non-granted source during STREAM, the losing source in a tie, and an SOF on an ineligible source in mode 0/1. drop_cnt saturates at 16'hFFFF and clears only on reset.
- When undefined: no counter logic; drop_cnt is tied to 16'h0000.

Test Plan (IMG_WIDTH = 4, IMG_HEIGHT = 2 unless noted):
1. Mode 0, src0 sends a clean 8-beat frame with data 1..8 -> m_axis carries 1..8 one cycle delayed, tuser on beat 1, tlast on beats 4 and 8; busy falls after beat 8; err_* stay 0.
2. Mode 2, both sources assert SOF in the same cycle for 3 consecutive frames -> grants src0, src1, src0; active_src follows; with the macro defined, drop_cnt = 3.
3. Mode 3, src1 SOF 2 cycles before src0 SOF -> src1 granted and its whole frame forwarded; src0 frame discarded; drop_cnt = 1 (macro on).
4. src0 sends tlast on its 3rd beat -> err_line pulses once, aligned with that output beat; line_cnt advances; the frame ends after the second tlast.
5. src0 reasserts SOF after 5 beats -> err_frame pulses; counters restart; the next 8 beats complete the frame and busy drops.
6. Reset pulsed low mid-line, then src0 non-SOF beats followed by an SOF -> outputs 0 during and after reset; forwarding resumes only from the SOF beat; drop_cnt = 0.

Source files
------------

// File: rtl/video_frame_arbiter.sv
// video_frame_arbiter: frame-level arbiter of two AXI-stream video sources.
// Optional dropped-frame counter: VIDEO_FRAME_ARBITER_DROP_CNT_EN.
module video_frame_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  pixel_clk,
  input  logic                  pixel_rst_n,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tlast,
  input  logic                  s0_axis_tuser,
  input  logic                  s0_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tlast,
  input  logic                  s1_axis_tuser,
  input  logic                  s1_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tvalid,
  output logic                  active_src,
  output logic                  busy,
  output logic                  err_line,
  output logic                  err_frame,
  output logic [15:0]           drop_cnt
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [11:0] PIX_LAST  = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] LINE_LAST = 12'(IMG_HEIGHT - 1);

  state_t state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   last_src_q, last_src_d;
  logic [11:0] pix_q, pix_d;
  logic [11:0] line_q, line_d;

  logic [DATA_WIDTH-1:0] m_data_q;
  logic m_last_q, m_user_q, m_valid_q;
  logic act_q, busy_q;
  logic err_line_q, err_line_d;
  logic err_frame_q, err_frame_d;

  logic sof0, sof1, e0, e1;
  logic pick, grant, sel, take;
  logic sel_v, sel_u, sel_l, sel_sof;
  logic [DATA_WIDTH-1:0] sel_d;
  logic [11:0] base_pix, base_line;

  assign sof0 = s0_axis_tvalid & s0_axis_tuser;
  assign sof1 = s1_axis_tvalid & s1_axis_tuser;
  assign e0   = sof0 & (cfg_mode != 2'd1);
  assign e1   = sof1 & (cfg_mode != 2'd0);
  assign grant = e0 | e1;

  // Choose which eligible SOF wins an IDLE decision
  always_comb begin
    pick = 1'b0;
    priority case (1'b1)
      e0 & e1: pick = (cfg_mode == 2'd2) ? ~last_src_q : 1'b0;
      e0:      pick = 1'b0;
      e1:      pick = 1'b1;
      default: pick = 1'b0;
    endcase
  end

  assign sel     = (state_q == IDLE) ? pick : gnt_q;
  assign sel_v   = sel ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_u   = sel ? s1_axis_tuser  : s0_axis_tuser;
  assign sel_l   = sel ? s1_axis_tlast  : s0_axis_tlast;
  assign sel_d   = sel ? s1_axis_tdata  : s0_axis_tdata;
  assign sel_sof = sel_v & sel_u;

  assign base_pix  = sel_sof ? 12'd0 : pix_q;
  assign base_line = sel_sof ? 12'd0 : line_q;

  // Grant decision, line/frame counting and error detection
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_src_d  = last_src_q;
    pix_d       = pix_q;
    line_d      = line_q;
    take        = 1'b0;
    err_line_d  = 1'b0;
    err_frame_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          take    = 1'b1;
          gnt_d   = pick;
          state_d = STREAM;
        end
      end
      STREAM: begin
        take        = sel_v;
        err_frame_d = sel_sof & ((pix_q != 12'd0) | (line_q != 12'd0));
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      if (sel_l) begin
        err_line_d = (base_pix != PIX_LAST);
        pix_d      = 12'd0;
        if (base_line == LINE_LAST) begin
          line_d     = 12'd0;
          state_d    = IDLE;
          last_src_d = sel;
        end else begin
          line_d = base_line + 12'd1;
        end
      end else begin
        pix_d  = base_pix + 12'd1;
        line_d = base_line;
      end
    end
  end

  // Arbiter state and counters
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_src_q <= 1'b1;
      pix_q      <= 12'd0;
      line_q     <= 12'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_src_q <= last_src_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
    end
  end

  // Output register stage; status aligned with the forwarded beat
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_user_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      act_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      m_data_q    <= take ? sel_d : '0;
      m_last_q    <= take & sel_l;
      m_user_q    <= take & sel_u;
      m_valid_q   <= take;
      busy_q      <= (state_q == STREAM) | grant;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
      if ((state_q == IDLE) && grant) begin
        act_q <= pick;
      end
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tvalid = m_valid_q;
  assign active_src    = act_q;
  assign busy          = busy_q;
  assign err_line      = err_line_q;
  assign err_frame     = err_frame_q;

`ifdef VIDEO_FRAME_ARBITER_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;
  logic        drop0, drop1;
  logic [16:0] drop_sum;

  assign drop0    = sof0 & ~(take & ~sel);
  assign drop1    = sof1 & ~(take & sel);
  assign drop_sum = {1'b0, drop_q} + {16'd0, drop0} + {16'd0, drop1};
  assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  // Saturating count of SOFs that lost arbitration
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      drop_q <= 16'h0000;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_video_frame_arbiter.sv
// tb_video_frame_arbiter: vector table plus scoreboard bench
// for video_frame_arbiter with IMG_WIDTH=4, IMG_HEIGHT=2.
module tb_video_frame_arbiter;

`ifdef VIDEO_FRAME_ARBITER_DROP_CNT_EN
  localparam int DROP_ON = 1;
`else
  localparam int DROP_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic [7:0] s0_tdata = '0, s1_tdata = '0;
  logic       s0_tlast = 0, s0_tuser = 0, s0_tvalid = 0;
  logic       s1_tlast = 0, s1_tuser = 0, s1_tvalid = 0;
  logic [7:0] m_tdata;
  logic       m_tlast, m_tuser, m_tvalid;
  logic       active_src, busy, err_line, err_frame;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  video_frame_arbiter #(
    .DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(2)
  ) dut (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .cfg_mode(cfg_mode),
    .s0_axis_tdata(s0_tdata), .s0_axis_tlast(s0_tlast),
    .s0_axis_tuser(s0_tuser), .s0_axis_tvalid(s0_tvalid),
    .s1_axis_tdata(s1_tdata), .s1_axis_tlast(s1_tlast),
    .s1_axis_tuser(s1_tuser), .s1_axis_tvalid(s1_tvalid),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid),
    .active_src(active_src), .busy(busy),
    .err_line(err_line), .err_frame(err_frame),
    .drop_cnt(drop_cnt)
  );

  // beat: {valid, user, last, data}; expect: {beat, err_line, err_frame, busy, act}
  typedef struct {
    logic [1:0]  mode;
    logic [10:0] b0;
    logic [10:0] b1;
    logic [14:0] exp;
  } vec_t;

  localparam logic [10:0] NB = 11'd0;

  vec_t        tbl[$];
  logic [14:0] sb[$];
  int          nvec = 0;
  int          nerr = 0;

  function automatic logic [10:0] bt(input logic u, input logic l,
                                     input logic [7:0] d);
    return {1'b1, u, l, d};
  endfunction

  function automatic logic [14:0] ex(input logic [10:0] b, input logic el,
                                     input logic ef, input logic bz,
                                     input logic ac);
    return {b, el, ef, bz, ac};
  endfunction

  task automatic add(input logic [1:0] m, input logic [10:0] b0,
                     input logic [10:0] b1, input logic [14:0] e);
    vec_t v;
    v.mode = m; v.b0 = b0; v.b1 = b1; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drv(input logic [1:0] m, input logic [10:0] b0,
                     input logic [10:0] b1);
    cfg_mode  = m;
    s0_tvalid = b0[10]; s0_tuser = b0[9]; s0_tlast = b0[8];
    s0_tdata  = b0[7:0];
    s1_tvalid = b1[10]; s1_tuser = b1[9]; s1_tlast = b1[8];
    s1_tdata  = b1[7:0];
  endtask

  task automatic chk_out(input string tag, input int idx);
    logic [14:0] got, want;
    got = {m_tvalid, m_tuser, m_tlast, m_tdata,
           err_line, err_frame, busy, active_src};
    nvec++;
    if (sb.size() == 0) begin
      nerr++;
      $display("FAIL %s[%0d] scoreboard empty, got %h", tag, idx, got);
    end else begin
      want = sb.pop_front();
      if (got !== want) begin
        nerr++;
        $display("FAIL %s[%0d] got %h want %h", tag, idx, got, want);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic run(input string tag);
    logic [1:0] m;
    m = 2'd0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      if (i > 0) chk_out(tag, i - 1);
      m = tbl[i].mode;
      drv(tbl[i].mode, tbl[i].b0, tbl[i].b1);
      sb.push_back(tbl[i].exp);
    end
    @(posedge clk); #1;
    chk_out(tag, tbl.size() - 1);
    drv(m, NB, NB);
    tbl.delete();
  endtask

  function automatic logic [30:0] outs();
    return {m_tvalid, m_tuser, m_tlast, m_tdata, err_line,
            err_frame, busy, active_src, drop_cnt};
  endfunction

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    drv(cfg_mode, NB, NB);
    rst_n = 1'b0;
    #3;
    chk({tag, "_rst"}, {1'b0, outs()}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic g;
    logic [10:0] b0, b1;
    logic [7:0] d0, d1;

    do_reset("init");

    // 1: clean frame on src0, a gap, src1 noise and an ineligible SOF
    add(0, bt(1,0,1), bt(1,0,8'hA0), ex(bt(1,0,1),0,0,1,0));
    add(0, bt(0,0,2), bt(0,0,8'hA1), ex(bt(0,0,2),0,0,1,0));
    add(0, bt(0,0,3), NB,            ex(bt(0,0,3),0,0,1,0));
    add(0, bt(0,1,4), bt(0,1,8'hA2), ex(bt(0,1,4),0,0,1,0));
    add(0, NB,        NB,            ex(NB,0,0,1,0));
    add(0, bt(0,0,5), NB,            ex(bt(0,0,5),0,0,1,0));
    add(0, bt(0,0,6), NB,            ex(bt(0,0,6),0,0,1,0));
    add(0, bt(0,0,7), NB,            ex(bt(0,0,7),0,0,1,0));
    add(0, bt(0,1,8), NB,            ex(bt(0,1,8),0,0,1,0));
    add(0, NB,        NB,            ex(NB,0,0,0,0));
    run("t1");
    chk("t1_drop", {16'd0, drop_cnt}, DROP_ON);

    // 2: round-robin with simultaneous SOFs on three back-to-back frames
    do_reset("t2");
    for (int f = 0; f < 3; f++) begin
      g = (f % 2) == 1;
      for (int k = 0; k < 8; k++) begin
        d0 = 8'(16 + 8 * f + k);
        d1 = 8'(128 + 8 * f + k);
        b0 = bt(k == 0, (k == 3) || (k == 7), d0);
        b1 = bt(k == 0, (k == 3) || (k == 7), d1);
        add(2, b0, b1, ex(g ? b1 : b0, 0, 0, 1, g));
      end
    end
    add(2, NB, NB, ex(NB,0,0,0,0));
    run("t2");
    chk("t2_drop", {16'd0, drop_cnt}, 3 * DROP_ON);

    // 3: fixed priority, src1 SOF first keeps the grant for its frame
    do_reset("t3");
    for (int r = 0; r < 10; r++) begin
      b1 = (r < 8) ? bt(r == 0, (r == 3) || (r == 7), 8'(8'h40 + r)) : NB;
      b0 = (r >= 2) ? bt(r == 2, (r == 5) || (r == 9), 8'(r)) : NB;
      add(3, b0, b1, (r < 8) ? ex(b1,0,0,1,1) : ex(NB,0,0,0,1));
    end
    add(3, NB, NB, ex(NB,0,0,0,1));
    run("t3");
    chk("t3_drop", {16'd0, drop_cnt}, DROP_ON);

    // 4: short first line flags err_line; frame still ends on 2nd tlast
    do_reset("t4");
    add(0, bt(1,0,1), NB, ex(bt(1,0,1),0,0,1,0));
    add(0, bt(0,0,2), NB, ex(bt(0,0,2),0,0,1,0));
    add(0, bt(0,1,3), NB, ex(bt(0,1,3),1,0,1,0));
    add(0, bt(0,0,4), NB, ex(bt(0,0,4),0,0,1,0));
    add(0, bt(0,0,5), NB, ex(bt(0,0,5),0,0,1,0));
    add(0, bt(0,0,6), NB, ex(bt(0,0,6),0,0,1,0));
    add(0, bt(0,1,7), NB, ex(bt(0,1,7),0,0,1,0));
    add(0, bt(0,0,9), NB, ex(NB,0,0,0,0));
    run("t4");

    // 5: SOF mid-frame restarts the frame with err_frame
    do_reset("t5");
    add(0, bt(1,0,1), NB, ex(bt(1,0,1),0,0,1,0));
    add(0, bt(0,0,2), NB, ex(bt(0,0,2),0,0,1,0));
    add(0, bt(0,0,3), NB, ex(bt(0,0,3),0,0,1,0));
    add(0, bt(0,1,4), NB, ex(bt(0,1,4),0,0,1,0));
    add(0, bt(0,0,5), NB, ex(bt(0,0,5),0,0,1,0));
    add(0, bt(1,0,6), NB, ex(bt(1,0,6),0,1,1,0));
    for (int k = 1; k < 8; k++) begin
      b0 = bt(0, (k == 3) || (k == 7), 8'(6 + k));
      add(0, b0, NB, ex(b0,0,0,1,0));
    end
    add(0, NB, NB, ex(NB,0,0,0,0));
    run("t5");

    // 6: reset mid-line abandons the frame; only a fresh SOF restarts
    do_reset("t6");
    add(0, bt(1,0,1), NB, ex(bt(1,0,1),0,0,1,0));
    add(0, bt(0,0,2), NB, ex(bt(0,0,2),0,0,1,0));
    run("t6a");
    @(posedge clk); #1;
    drv(0, bt(0,0,3), NB);
    rst_n = 1'b0;
    #2;
    chk("t6_during", {1'b0, outs()}, 32'd0);
    @(posedge clk); #1;
    chk("t6_held", {1'b0, outs()}, 32'd0);
    rst_n = 1'b1;
    add(0, bt(0,0,4), NB, ex(NB,0,0,0,0));
    add(0, bt(0,0,5), NB, ex(NB,0,0,0,0));
    for (int k = 0; k < 8; k++) begin
      b0 = bt(k == 0, (k == 3) || (k == 7), 8'(6 + k));
      add(0, b0, NB, ex(b0,0,0,1,0));
    end
    add(0, NB, NB, ex(NB,0,0,0,0));
    run("t6b");
    chk("t6_drop", {16'd0, drop_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
